mac16_fir_driver: RTL and testbench



---
 rtl/fir_drv_pkg.sv | 28 ++
 rtl/q15_round_sat.sv | 36 +++
 rtl/mac16_fir_driver.sv | 154 +++++++++++++++
 tb/tb_mac16_fir_driver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_drv_pkg.sv
// ---------------------------------------------------------------------------
// fir_drv_pkg
// Shared types and constants for the MAC16 FIR operand sequencer:
//   - state_e  : sequencer FSM states
//   - DATA_W   : Q15 sample/coefficient/result width
//   - ACC_W    : MAC16 accumulator width
//   - Q_SHIFT  : binary point position of the Q30 product sum
//   - ROUND_K  : round-half-up constant added before the shift
//   - SAT_MAX / SAT_MIN : Q15 saturation limits
// ---------------------------------------------------------------------------
package fir_drv_pkg;

   localparam int DATA_W  = 16;
   localparam int ACC_W   = 32;
   localparam int Q_SHIFT = 15;

   localparam logic [ACC_W-1:0]  ROUND_K = 32'h0000_4000;
   localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      OUTPUT = 2'd3
   } state_e;

endpackage

// File: rtl/q15_round_sat.sv
// ---------------------------------------------------------------------------
// q15_round_sat
// Combinational conversion of a 32-bit Q30 accumulator to Q15: add the
// round-half-up constant in 33 bits, arithmetic shift right by 15, then clamp
// to the signed 16-bit range. Out-of-range results are clamped silently.
// Ports:
//   acc_i  in  32  signed accumulator value
//   q_o    out 16  signed rounded, saturated Q15 value
// ---------------------------------------------------------------------------
module q15_round_sat
   import fir_drv_pkg::*;
(
   input  logic signed [ACC_W-1:0]  acc_i,
   output logic signed [DATA_W-1:0] q_o
);

   localparam int SH_W = ACC_W - Q_SHIFT + 1;

   function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W:0]  sum;
      logic signed [SH_W-1:0] shr;
      // One guard bit so the rounding add cannot wrap at the positive end.
      sum = {acc[ACC_W-1], acc} + $signed({1'b0, ROUND_K});
      // Slicing the top bits of a signed value is an arithmetic shift.
      shr = sum[ACC_W:Q_SHIFT];
      if (shr > $signed({{(SH_W-DATA_W){1'b0}}, SAT_MAX}))
         return $signed(SAT_MAX);
      else if (shr < $signed({{(SH_W-DATA_W){1'b1}}, SAT_MIN}))
         return $signed(SAT_MIN);
      else
         return shr[DATA_W-1:0];
   endfunction

   assign q_o = round_sat(acc_i);

endmodule

// File: rtl/mac16_fir_driver.sv
// ---------------------------------------------------------------------------
// mac16_fir_driver
// Operand sequencer for a MAC16 hard block running 16x16 signed MAC. Each
// accepted Q15 sample is written into a circular history; NUM_TAPS
// coefficient/sample pairs are then streamed into the MAC, the accumulator is
// captured after the MAC pipeline drains, rounded/saturated to Q15 and held on
// a valid/ready output. Frames never overlap.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   s_valid/s_ready/s_data   sample input handshake (s_ready only in IDLE)
//   coef_addr/coef_data      coefficient ROM, 1-cycle read latency
//   mac_a/mac_b              MAC16 A (coefficient) / B (sample)
//   mac_hld                  shared AHLD/BHLD/OHHLD/OLHLD, low while streaming
//   mac_lda                  OHLDA/OLLDA, loads first product into accumulator
//   mac_o                    MAC16 accumulator output
//   y_valid/y_ready/y_data   result output handshake
//   busy                     sequencer not idle
// ---------------------------------------------------------------------------
module mac16_fir_driver
   import fir_drv_pkg::*;
#(
   parameter int NUM_TAPS = 16,
   parameter int MAC_LAT  = 3,
   parameter int AW       = $clog2(NUM_TAPS)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [DATA_W-1:0] s_data,
   output logic [AW-1:0]            coef_addr,
   input  logic signed [DATA_W-1:0] coef_data,
   output logic signed [DATA_W-1:0] mac_a,
   output logic signed [DATA_W-1:0] mac_b,
   output logic                     mac_hld,
   output logic                     mac_lda,
   input  logic signed [ACC_W-1:0]  mac_o,
   output logic                     y_valid,
   input  logic                     y_ready,
   output logic signed [DATA_W-1:0] y_data,
   output logic                     busy
);

   localparam int DW = 3;

   state_e                    state_q, state_d;
   logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]             coef_addr_q, coef_addr_d;
   logic [DW-1:0]             drain_q, drain_d;
   logic                      y_valid_q, y_valid_d;
   logic signed [DATA_W-1:0]  y_data_q, y_data_d;
   logic signed [DATA_W-1:0]  hist_q [NUM_TAPS];
   logic signed [DATA_W-1:0]  samp_q;
   logic signed [DATA_W-1:0]  a_hold_q;
   logic                      hld_q;
   logic [MAC_LAT-1:0]        lda_sr_q;
   logic signed [DATA_W-1:0]  rs_q;

   q15_round_sat u_round_sat (
      .acc_i (mac_o),
      .q_o   (rs_q)
   );

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      coef_addr_d = coef_addr_q;
      drain_d     = drain_q;
      y_valid_d   = y_valid_q;
      y_data_d    = y_data_q;
      case (state_q)
         IDLE: begin
            if (s_valid) begin
               state_d     = ISSUE;
               coef_addr_d = '0;
            end
         end
         ISSUE: begin
            // Address wraps back to 0 after the last tap (NUM_TAPS is 2^AW).
            coef_addr_d = coef_addr_q + 1'b1;
            if (coef_addr_q == AW'(NUM_TAPS - 1)) begin
               state_d = DRAIN;
               drain_d = '0;
            end
         end
         DRAIN: begin
            // drain_q counts cycles since the last tap left ISSUE; after
            // MAC_LAT of them mac_o holds the complete sum.
            drain_d = drain_q + 1'b1;
            if (drain_q == DW'(MAC_LAT)) begin
               state_d   = OUTPUT;
               y_valid_d = 1'b1;
               y_data_d  = rs_q;
            end
         end
         OUTPUT: begin
            if (y_ready) begin
               state_d   = IDLE;
               y_valid_d = 1'b0;
               wr_ptr_d  = wr_ptr_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         coef_addr_q <= '0;
         drain_q     <= '0;
         y_valid_q   <= 1'b0;
         y_data_q    <= '0;
         samp_q      <= '0;
         a_hold_q    <= '0;
         hld_q       <= 1'b1;
         lda_sr_q    <= '0;
         for (int i = 0; i < NUM_TAPS; i++) hist_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         coef_addr_q <= coef_addr_d;
         drain_q     <= drain_d;
         y_valid_q   <= y_valid_d;
         y_data_q    <= y_data_d;

         // Stage p0: sample capture at the input handshake.
         if (state_q == IDLE && s_valid) hist_q[wr_ptr_q] <= s_data;

         // Stage p1: sample fetch for tap k, newest first, alongside the ROM read.
         if (state_q == ISSUE) samp_q <= hist_q[wr_ptr_q - coef_addr_q];
         hld_q <= (state_q != ISSUE);

         // Stage p2: operands presented to the MAC; lda rides MAC_LAT deep from tap 0.
         if (!hld_q) a_hold_q <= coef_data;
         lda_sr_q <= {lda_sr_q[MAC_LAT-2:0], (state_q == ISSUE && coef_addr_q == '0)};
      end
   end

   // The ROM output for tap k arrives in the same cycle mac_b carries the
   // matching sample, so it is passed straight through while streaming and a
   // captured copy keeps mac_a steady whenever the MAC is on hold.
   assign mac_a     = hld_q ? a_hold_q : coef_data;
   assign mac_b     = samp_q;
   assign mac_hld   = hld_q;
   assign mac_lda   = lda_sr_q[MAC_LAT-1];
   assign coef_addr = coef_addr_q;
   assign s_ready   = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign y_valid   = y_valid_q;
   assign y_data    = y_data_q;

endmodule

// File: tb/tb_mac16_fir_driver.sv
module tb_mac16_fir_driver;

   localparam int N  = 16;
   localparam int ML = 3;
   localparam int AW = 4;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               s_valid = 1'b0;
   logic               s_ready;
   logic signed [15:0] s_data = '0;
   logic [AW-1:0]      coef_addr;
   logic signed [15:0] coef_data = '0;
   logic signed [15:0] mac_a, mac_b;
   logic               mac_hld, mac_lda;
   logic signed [31:0] mac_o;
   logic               y_valid;
   logic               y_ready = 1'b0;
   logic signed [15:0] y_data;
   logic               busy;

   logic signed [31:0] rs_acc = '0;
   logic signed [15:0] rs_q;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   mac16_fir_driver #(.NUM_TAPS(N), .MAC_LAT(ML), .AW(AW)) dut (
      .CLK(CLK), .RST(RST),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .coef_addr(coef_addr), .coef_data(coef_data),
      .mac_a(mac_a), .mac_b(mac_b), .mac_hld(mac_hld), .mac_lda(mac_lda),
      .mac_o(mac_o),
      .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
      .busy(busy)
   );

   q15_round_sat u_rs (.acc_i(rs_acc), .q_o(rs_q));

   // Coefficient ROM with one cycle of read latency.
   logic signed [15:0] coef_mem [N];
   always @(posedge CLK) coef_data <= coef_mem[coef_addr];

   // MAC16 model: A/B input registers, product register, accumulator.
   // Holds travel with the operands so each product accumulates exactly once.
   logic signed [15:0] ma_q, mb_q;
   logic signed [31:0] p_q, acc_q;
   logic               v1_q, v2_q;
   always @(posedge CLK) begin
      if (RST) begin
         ma_q <= '0; mb_q <= '0; p_q <= '0; acc_q <= '0; v1_q <= 1'b0; v2_q <= 1'b0;
      end else begin
         if (!mac_hld) begin
            ma_q <= mac_a;
            mb_q <= mac_b;
         end
         v1_q <= !mac_hld;
         p_q  <= ma_q * mb_q;
         v2_q <= v1_q;
         if (v2_q) acc_q <= mac_lda ? p_q : acc_q + p_q;
      end
   end
   assign mac_o = acc_q;

   // Reference FIR: newest sample times coef[0], plain integer arithmetic.
   int href [N];
   int hw = 0;

   function automatic logic signed [15:0] ref_q15(input longint s);
      longint r;
      r = (s + 64'sd16384) >>> 15;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      return 16'(r);
   endfunction

   function automatic logic signed [15:0] ref_push(input int x);
      longint s;
      href[hw] = x;
      s = 0;
      for (int k = 0; k < N; k++) s += longint'(coef_mem[k]) * longint'(href[(hw - k + N) % N]);
      hw = (hw + 1) % N;
      return ref_q15(s);
   endfunction

   function automatic void ref_clear();
      for (int i = 0; i < N; i++) href[i] = 0;
      hw = 0;
   endfunction

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // One complete frame. Entered and left at 1 time unit after a rising edge.
   task automatic do_frame(input logic signed [15:0] x, input logic signed [15:0] exp,
                           input int stall, input bit early, input bit chk_ctl, input string tag);
      int n, lat, hld_cnt, hld_first, lda_cnt, lda_at, bad;
      logic signed [15:0] y_hold;
      n = 0;
      while (!s_ready && n < 50) begin
         @(posedge CLK); #1; n++;
      end
      if (!s_ready) begin
         chk({tag, "_s_ready_timeout"}, 0, 1);
         return;
      end
      s_valid = 1'b1;
      s_data  = x;
      @(posedge CLK); #1;
      s_valid = 1'b0;
      s_data  = 16'($urandom);
      if (early) y_ready = 1'b1;
      lat = 1; hld_cnt = 0; hld_first = -1; lda_cnt = 0; lda_at = -1;
      while (!y_valid && lat < 200) begin
         if (!mac_hld) begin
            hld_cnt++;
            if (hld_first < 0) hld_first = lat;
         end
         if (mac_lda) begin
            lda_cnt++;
            lda_at = lat;
         end
         @(posedge CLK); #1; lat++;
      end
      if (!y_valid) begin
         chk({tag, "_y_valid_timeout"}, 0, 1);
         y_ready = 1'b0;
         return;
      end
      chk(tag, y_data, exp);
      if (chk_ctl) begin
         chk("latency", lat, N + ML + 2);
         chk("hld_low_cycles", hld_cnt, N);
         chk("hld_first_low", hld_first, 2);
         chk("lda_pulses", lda_cnt, 1);
         chk("lda_cycle", lda_at, ML + 1);
      end
      if (early) begin
         @(posedge CLK); #1;
         y_ready = 1'b0;
         chk({tag, "_early_ready_done"}, y_valid, 0);
         return;
      end
      y_hold = y_data;
      bad = 0;
      for (int i = 0; i < stall; i++) begin
         s_valid = 1'b1;
         s_data  = 16'($urandom);
         @(posedge CLK); #1;
         if (y_data !== y_hold || s_ready !== 1'b0 || y_valid !== 1'b1) bad++;
      end
      s_valid = 1'b0;
      if (stall > 0) chk({tag, "_stall_stable"}, bad, 0);
      y_ready = 1'b1;
      @(posedge CLK); #1;
      y_ready = 1'b0;
      if (stall > 0) begin
         chk({tag, "_s_ready_after_release"}, s_ready, 1);
         chk({tag, "_y_valid_after_release"}, y_valid, 0);
      end
   endtask

   typedef struct {
      logic signed [15:0] x;
      logic signed [15:0] y;
   } frame_vec_t;

   typedef struct {
      logic signed [31:0] acc;
      logic signed [15:0] q;
   } rs_vec_t;

   frame_vec_t imp_tab [N];
   rs_vec_t    rs_tab  [12];
   logic signed [15:0] r;

   task automatic run_impulse(input string tag, input bit chk_ctl);
      for (int k = 0; k < N; k++) coef_mem[k] = 16'(16'h0100 * (k + 1));
      for (int i = 0; i < N; i++) begin
         r = ref_push(imp_tab[i].x);
         do_frame(imp_tab[i].x, imp_tab[i].y, 0, 1'b0, chk_ctl && (i == 0), tag);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         imp_tab[i].x = (i == 0) ? 16'sh7FFF : 16'sh0000;
         imp_tab[i].y = 16'(16'h0100 * (i + 1));
      end
      rs_tab[0]  = '{32'sh0000_0000, 16'sh0000};
      rs_tab[1]  = '{32'sh0000_4000, 16'sh0001};
      rs_tab[2]  = '{32'sh0000_3FFF, 16'sh0000};
      rs_tab[3]  = '{32'shFFFF_C000, 16'sh0000};
      rs_tab[4]  = '{32'shFFFF_BFFF, 16'shFFFF};
      rs_tab[5]  = '{32'sh3FFF_8000, 16'sh7FFF};
      rs_tab[6]  = '{32'sh3FFF_C000, 16'sh7FFF};
      rs_tab[7]  = '{32'sh7FFF_FFFF, 16'sh7FFF};
      rs_tab[8]  = '{32'sh8000_0000, 16'sh8000};
      rs_tab[9]  = '{32'shC000_0000, 16'sh8000};
      rs_tab[10] = '{32'shBFFF_8000, 16'sh8000};
      rs_tab[11] = '{32'sh0080_0000, 16'sh0100};
      for (int k = 0; k < N; k++) coef_mem[k] = '0;
      ref_clear();

      // Standalone round/saturate vectors.
      for (int i = 0; i < 12; i++) begin
         rs_acc = rs_tab[i].acc;
         #1;
         chk($sformatf("round_sat_%0d", i), rs_q, rs_tab[i].q);
      end

      // Reset state.
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_y_valid", y_valid, 0);
      chk("rst_y_data", y_data, 0);
      chk("rst_coef_addr", coef_addr, 0);
      chk("rst_mac_a", mac_a, 0);
      chk("rst_mac_b", mac_b, 0);
      chk("rst_mac_hld", mac_hld, 1);
      chk("rst_mac_lda", mac_lda, 0);
      chk("rst_busy", busy, 0);
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("rst_s_ready", s_ready, 1);

      // Impulse response plus latency/control timing on the first frame.
      run_impulse("impulse", 1'b1);

      // Positive then negative saturation.
      for (int k = 0; k < N; k++) coef_mem[k] = (k < 4) ? 16'sh4000 : 16'sh0000;
      for (int i = 0; i < 6; i++) begin
         r = ref_push(16'sh7FFF);
         do_frame(16'sh7FFF, (i >= 3) ? 16'sh7FFF : r, 0, 1'b0, 1'b0, "sat_pos");
      end
      for (int i = 0; i < 6; i++) begin
         r = ref_push(-32768);
         do_frame(16'sh8000, (i >= 3) ? 16'sh8000 : r, 0, 1'b0, 1'b0, "sat_neg");
      end

      // Random coefficients and samples, with backpressure and early y_ready.
      for (int k = 0; k < N; k++) coef_mem[k] = 16'($signed($urandom_range(0, 4095)) - 2048);
      for (int i = 0; i < 24; i++) begin
         logic signed [15:0] x;
         int st;
         bit early;
         x = 16'($urandom);
         st = (i == 0) ? 10 : int'($urandom_range(0, 3));
         early = (i % 5 == 4);
         r = ref_push(x);
         do_frame(x, r, st, early, 1'b0, $sformatf("rand_%0d", i));
      end

      // Reset in the middle of ISSUE abandons the frame and clears history.
      while (!s_ready) begin
         @(posedge CLK); #1;
      end
      s_valid = 1'b1;
      s_data  = 16'sh1234;
      @(posedge CLK); #1;
      s_valid = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      chk("mid_busy_before_rst", busy, 1);
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("mid_rst_mac_hld", mac_hld, 1);
      chk("mid_rst_mac_lda", mac_lda, 0);
      chk("mid_rst_y_valid", y_valid, 0);
      chk("mid_rst_s_ready", s_ready, 1);
      chk("mid_rst_busy", busy, 0);
      RST = 1'b0;
      ref_clear();
      repeat (ML + 3) @(posedge CLK);
      #1;
      chk("mid_rst_no_stale_y_valid", y_valid, 0);
      run_impulse("impulse_after_rst", 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
